gf2m_283_reduce: RTL and testbench
==================================

GF2M_283_REDUCE -- requirements
Module: gf2m_283_reduce

Interface
REQ-001 SHALL have parameter FOLD_W, default 71, giving product bits folded per cycle; legal range 1..271.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning c_in holds a product to reduce.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts c_in this cycle.
REQ-006 SHALL have port c_in, input, 566, the unreduced GF(2)[x] product (bit i = coefficient of x^i), as produced by the 283x283 binary multiplier.
REQ-007 SHALL have port out_valid, output, 1, meaning r_out holds a result.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer takes r_out this cycle.
REQ-009 SHALL have port r_out, output, 283, equal to c_in mod f(x), where f(x) = x^283 + x^12 + x^7 + x^5 + 1.

Function
REQ-010 SHALL implement the states IDLE, FOLD and DONE.
REQ-011 IDLE behaviour:
- in_ready SHALL be 1.
- in_valid=1 SHALL load c_in into a 566-bit work register, clear the fold counter, and move to FOLD.
REQ-012 in_ready SHALL be 0 in FOLD and DONE; c_in SHALL be ignored there.
REQ-013 Fold count: FOLD SHALL last exactly N = ceil(283/FOLD_W) cycles (N=4 at default).
REQ-014 Fold k (k=0..N-1) window:
- Let L = 566 - k*FOLD_W.
- The window is bits [max(L-FOLD_W,283), L-1].
- The window SHALL be cleared.
- Each set bit p in the window SHALL be XORed into positions p-283+12, p-283+7, p-283+5 and p-283.
REQ-015 All operations SHALL be carry-less (XOR only); no integer addition on data.
REQ-016 After the last fold, bits [565:283] of the work register SHALL be zero, and the FSM SHALL enter DONE.
REQ-017 DONE behaviour:
- out_valid SHALL be 1.
- r_out SHALL equal work register bits [282:0].
- Both SHALL be held stable until out_ready=1.
REQ-018 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; out_valid SHALL be 0 the following cycle.
REQ-019 Latency: with the acceptance edge at t, out_valid SHALL rise after edge t+N, and the next in_ready SHALL be 1 no earlier than the cycle after the output handshake.
REQ-020 c_in bit 565 and any bits at or above 283 SHALL be reduced correctly, including all-ones inputs.

Reset
REQ-021 rst=1 SHALL immediately force:
- state = IDLE;
- in_ready = 1 (while rst is low on the next cycle);
- out_valid = 0;
- r_out = 0;
- work register = 0;
- fold counter = 0.
REQ-022 rst asserted mid-FOLD or in DONE SHALL discard the operation; no out_valid SHALL follow for it.

Structure
REQ-023 A shared package gf2m_283_pkg SHALL hold:
- M = 283;
- PROD_W = 566;
- the pentanomial tap list {12, 7, 5, 0};
- the state enum type.
REQ-024 A combinational sub-module gf2m_283_fold_slice SHALL perform one window fold (REQ-014) on a 566-bit vector, with the window upper bound as an input; it SHALL be instantiated once.
REQ-025 A static check SHALL reject FOLD_W outside 1..271.

Verification
REQ-026 c_in=0 -> r_out=0, out_valid rises exactly N cycles after acceptance.
REQ-027 c_in = x^283 (only bit 283 set) -> r_out = 0x10A1 (bits 12, 7, 5, 0).
REQ-028 c_in = x^564 -> r_out has exactly bits {281, 22, 12, 10, 8, 5, 3} set.
REQ-029 c_in with only bits [282:0] set, value 0x1234_5678_9ABC -> r_out = 0x1234_5678_9ABC.
REQ-030 out_ready held 0 for 5 cycles in DONE -> r_out and out_valid stable, in_ready=0 throughout; a new in_valid pulse in that time is not accepted.
REQ-031 Reset and random traffic:
- rst pulsed during the 2nd fold cycle -> out_valid stays 0, in_ready=1 after release.
- 1000 random c_in values with FOLD_W in {1, 71, 271} -> r_out matches a bitwise polynomial-mod reference model.

Source files
------------

// File: rtl/gf2m_283_pkg.sv
// Shared constants and types for the GF(2^283) reduction datapath.
// The field polynomial is f(x) = x^283 + x^12 + x^7 + x^5 + 1.
package gf2m_283_pkg;

    localparam int M        = 283;
    localparam int PROD_W   = 566;
    localparam int NUM_TAPS = 4;

    // Low-order exponents of f(x); x^283 folds back onto each of these.
    localparam int TAPS [NUM_TAPS] = '{12, 7, 5, 0};

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_t;

endpackage

// File: rtl/gf2m_283_fold_slice.sv
// One window fold: clears product bits [max(win_hi-FOLD_W,283), win_hi-1]
// and XORs each cleared bit back in at its x^283 == x^12+x^7+x^5+1 images.
module gf2m_283_fold_slice
    import gf2m_283_pkg::*;
#(
    parameter int FOLD_W = 71
) (
    input  logic [PROD_W-1:0] vec_in,
    input  logic [9:0]        win_hi,
    output logic [PROD_W-1:0] vec_out
);

    logic [9:0]        win_lo;
    logic [PROD_W-1:0] win_mask;
    logic [PROD_W-1:0] win_bits;

    // Every image lands below the window's lower edge, so the window can be
    // cleared and refolded in one pass without the images interacting.
    always_comb begin
        win_lo   = (win_hi >= 10'(M + FOLD_W)) ? (win_hi - 10'(FOLD_W)) : 10'(M);
        win_mask = ({PROD_W{1'b1}} << win_lo) & ~({PROD_W{1'b1}} << win_hi);
        win_bits = vec_in & win_mask;
        vec_out  = vec_in & ~win_mask;
        for (int t = 0; t < NUM_TAPS; t++) begin
            vec_out = vec_out ^ (win_bits >> (M - TAPS[t]));
        end
    end

endmodule

// File: rtl/gf2m_283_reduce.sv
// Multi-cycle reduction of a 566-bit carry-less product modulo the
// NIST B-283 pentanomial, folding FOLD_W high bits per cycle.
module gf2m_283_reduce
    import gf2m_283_pkg::*;
#(
    parameter int FOLD_W = 71
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      r_out
);

    localparam int N = (M + FOLD_W - 1) / FOLD_W;

    generate
        if (FOLD_W < 1 || FOLD_W > 271) begin : g_bad_fold_w
            $error("gf2m_283_reduce: FOLD_W must lie in 1..271");
        end
    endgenerate

    state_t            state;
    logic [8:0]        fold_cnt;
    logic [PROD_W-1:0] work;
    logic [PROD_W-1:0] folded;
    logic [9:0]        win_hi;

    // Fold k handles the window whose exclusive upper bound is 566 - k*FOLD_W.
    assign win_hi = 10'(PROD_W - int'(fold_cnt) * FOLD_W);

    gf2m_283_fold_slice #(
        .FOLD_W (FOLD_W)
    ) u_fold_slice (
        .vec_in  (work),
        .win_hi  (win_hi),
        .vec_out (folded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fold_cnt  <= '0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r_out     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= c_in;
                        fold_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= FOLD;
                    end
                end
                FOLD: begin
                    work     <= folded;
                    fold_cnt <= fold_cnt + 9'd1;
                    if (fold_cnt == 9'(N - 1)) begin
                        out_valid <= 1'b1;
                        r_out     <= folded[M-1:0];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_283_reduce.sv
// Scoreboard bench for gf2m_283_reduce at FOLD_W = 1, 71 and 271, checked
// against a long-division polynomial-mod reference.
module tb_gf2m_283_reduce;
    import gf2m_283_pkg::*;

    localparam int FW_LIST [3] = '{1, 71, 271};
    localparam int N_LIST  [3] = '{283, 4, 2};

    logic              clk = 1'b0;
    logic              rst;
    logic [PROD_W-1:0] c_in;
    logic              in_valid  [3];
    logic              in_ready  [3];
    logic              out_valid [3];
    logic              out_ready [3];
    logic [M-1:0]      r_out     [3];

    int           compared   = 0;
    int           mismatched = 0;
    logic [M-1:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gf2m_283_reduce #(
            .FOLD_W (FW_LIST[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .c_in      (c_in),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .r_out     (r_out[g])
        );
    end

    function automatic logic [M-1:0] ref_mod(input logic [PROD_W-1:0] c);
        logic [PROD_W-1:0] f;
        logic [PROD_W-1:0] r;
        f = '0;
        f[283] = 1'b1; f[12] = 1'b1; f[7] = 1'b1; f[5] = 1'b1; f[0] = 1'b1;
        r = c;
        for (int i = PROD_W - 1; i >= M; i--) begin
            if (r[i]) r = r ^ (f << (i - M));
        end
        return r[M-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [M-1:0] obs, input logic [M-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one product, wait (bounded) for the result, check latency and value.
    task automatic applyStimulus(input int idx, input logic [PROD_W-1:0] c,
                                 input logic [M-1:0] expv, input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready[idx] && cyc < 400) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_in_ready"}, M'(in_ready[idx]), M'(1));
        c_in          = c;
        in_valid[idx] = 1'b1;
        exp_q.push_back(expv);
        tick();
        in_valid[idx] = 1'b0;
        c_in          = '0;
        cyc = 0;
        while (!out_valid[idx] && cyc < 400) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, M'(cyc), M'(N_LIST[idx]));
        checkOutput({tag, "_r_out"}, r_out[idx], exp_q.pop_front());
    endtask

    task automatic handshake(input int idx, input string tag);
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        checkOutput({tag, "_hs_out_valid"}, M'(out_valid[idx]), M'(0));
        checkOutput({tag, "_hs_in_ready"}, M'(in_ready[idx]), M'(1));
    endtask

    initial begin
        logic [PROD_W-1:0] c;
        logic [M-1:0]      expv;
        logic              seen;
        int                idx;

        rst  = 1'b1;
        c_in = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", M'(out_valid[1]), M'(0));
        checkOutput("reset_r_out", r_out[1], '0);
        rst = 1'b0;
        tick();
        checkOutput("reset_in_ready", M'(in_ready[1]), M'(1));

        // Directed cases at the default fold width.
        applyStimulus(1, '0, '0, "zero");
        handshake(1, "zero");

        c = '0; c[283] = 1'b1;
        applyStimulus(1, c, M'(283'h10A1), "x283");
        handshake(1, "x283");

        c = '0; c[564] = 1'b1;
        expv = '0;
        expv[281] = 1'b1; expv[22] = 1'b1; expv[12] = 1'b1; expv[10] = 1'b1;
        expv[8] = 1'b1; expv[5] = 1'b1; expv[3] = 1'b1;
        applyStimulus(1, c, expv, "x564");
        handshake(1, "x564");

        applyStimulus(1, PROD_W'(48'h1234_5678_9ABC), M'(48'h1234_5678_9ABC), "low_only");
        handshake(1, "low_only");

        for (int i = 0; i < 3; i++) begin
            c = '1;
            applyStimulus(i, c, ref_mod(c), $sformatf("ones_fw%0d", FW_LIST[i]));
            handshake(i, $sformatf("ones_fw%0d", FW_LIST[i]));
        end

        // Stall in DONE with a stray in_valid pulse that must be ignored.
        c = '0; c[565] = 1'b1;
        expv = ref_mod(c);
        applyStimulus(1, c, expv, "stall");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                c_in        = {PROD_W{1'b1}};
                in_valid[1] = 1'b1;
            end
            tick();
            in_valid[1] = 1'b0;
            c_in        = '0;
            checkOutput($sformatf("stall%0d_out_valid", k), M'(out_valid[1]), M'(1));
            checkOutput($sformatf("stall%0d_r_out", k), r_out[1], expv);
            checkOutput($sformatf("stall%0d_in_ready", k), M'(in_ready[1]), M'(0));
        end
        handshake(1, "stall");
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid[1]) seen = 1'b1;
        end
        checkOutput("stall_no_ghost", M'(seen), M'(0));

        // Reset during the second fold cycle discards the operation.
        c_in        = {PROD_W{1'b1}};
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        c_in        = '0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", M'(out_valid[1]), M'(0));
        checkOutput("midrst_r_out", r_out[1], '0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid[1]) seen = 1'b1;
        end
        checkOutput("midrst_no_out", M'(seen), M'(0));
        checkOutput("midrst_in_ready", M'(in_ready[1]), M'(1));

        // Random traffic; FOLD_W=1 is slow so it takes one transaction in ten.
        for (int i = 0; i < 1000; i++) begin
            for (int w = 0; w < 18; w++) begin
                c[w*32 +: 32] = (w == 17) ? {10'd0, 22'($urandom)} : $urandom;
            end
            if (i % 97 == 5) c = '1;
            idx = (i % 10 == 0) ? 0 : ((i % 2 == 1) ? 1 : 2);
            applyStimulus(idx, c, ref_mod(c), $sformatf("rand%0d", i));
            handshake(idx, $sformatf("rand%0d", i));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
